// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - in-order store buffer with store-to-load forwarding
//
// Purpose: buffers committed stores, drains them to the memory write port
// when it is ready, and serves loads either from the youngest matching
// buffered store or from the memory read port. Load results are registered.
//
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   st_valid_i/addr/data      store request in; st_ready_o accepts it
//   ld_en_i, ld_addr_i        load request in
//   ld_data_o/valid_o/fwd_o   registered load result, one cycle after ld_en_i
//   mem_write_*               drain port (head entry), mem_write_rdy_i pops
//   mem_read_*                pass-through read port for load misses
//   empty_o, count_o          occupancy status
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid_i,
  input  logic [AW-1:0]              st_addr_i,
  input  logic [DW-1:0]              st_data_i,
  output logic                       st_ready_o,
  input  logic                       ld_en_i,
  input  logic [AW-1:0]              ld_addr_i,
  output logic [DW-1:0]              ld_data_o,
  output logic                       ld_valid_o,
  output logic                       ld_fwd_o,
  output logic                       mem_write_en_o,
  output logic [AW-1:0]              mem_addr_store_o,
  output logic [DW-1:0]              mem_write_data_o,
  input  logic                       mem_write_rdy_i,
  output logic                       mem_read_en_o,
  output logic [AW-1:0]              mem_addr_load_o,
  input  logic [DW-1:0]              mem_read_data_i,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic          hit;
  logic [DW-1:0] fwd_data;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign mem_write_en_o   = !empty;
  assign mem_addr_store_o = addr_q[rd_ptr[PW-1:0]];
  assign mem_write_data_o = data_q[rd_ptr[PW-1:0]];

  assign pop        = mem_write_en_o & mem_write_rdy_i;
  // A full buffer still takes a store when the head leaves in the same cycle.
  assign st_ready_o = !full | pop;
  assign push       = st_valid_i & st_ready_o;

  assign empty_o = empty;
  assign count_o = count;

  // Walk entries from oldest to youngest; later matches override earlier
  // ones so the youngest matching store wins. The head being popped this
  // cycle is still occupied and still forwards.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) &&
          (addr_q[rd_ptr[PW-1:0] + PW'(i)][AW-1:3] == ld_addr_i[AW-1:3])) begin
        hit      = 1'b1;
        fwd_data = data_q[rd_ptr[PW-1:0] + PW'(i)];
      end
    end
  end

  assign mem_read_en_o   = ld_en_i & !hit;
  assign mem_addr_load_o = ld_addr_i;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr[PW-1:0]] <= st_addr_i;
      data_q[wr_ptr[PW-1:0]] <= st_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ld_data_o  <= '0;
      ld_valid_o <= 1'b0;
      ld_fwd_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      ld_valid_o <= ld_en_i;
      if (ld_en_i) begin
        ld_data_o <= hit ? fwd_data : mem_read_data_i;
        ld_fwd_o  <= hit;
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid_i;
  logic [AW-1:0] st_addr_i;
  logic [DW-1:0] st_data_i;
  logic          st_ready_o;
  logic          ld_en_i;
  logic [AW-1:0] ld_addr_i;
  logic [DW-1:0] ld_data_o;
  logic          ld_valid_o;
  logic          ld_fwd_o;
  logic          mem_write_en_o;
  logic [AW-1:0] mem_addr_store_o;
  logic [DW-1:0] mem_write_data_o;
  logic          mem_write_rdy_i;
  logic          mem_read_en_o;
  logic [AW-1:0] mem_addr_load_o;
  logic [DW-1:0] mem_read_data_i;
  logic          empty_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_ready_o(st_ready_o),
    .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_data_o(ld_data_o),
    .ld_valid_o(ld_valid_o), .ld_fwd_o(ld_fwd_o),
    .mem_write_en_o(mem_write_en_o), .mem_addr_store_o(mem_addr_store_o),
    .mem_write_data_o(mem_write_data_o), .mem_write_rdy_i(mem_write_rdy_i),
    .mem_read_en_o(mem_read_en_o), .mem_addr_load_o(mem_addr_load_o),
    .mem_read_data_i(mem_read_data_i),
    .empty_o(empty_o), .count_o(count_o)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_d = '0;
  logic          last_f = 1'b0;
  int            passed = 0;
  int            total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit model_ready(input logic rdy);
    return (q.size() < DEPTH) || ((q.size() > 0) && rdy);
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic le, input logic [AW-1:0] la,
                      input logic rdy, input logic [DW-1:0] mrd);
    bit            pop, rdy_exp, hit;
    logic [DW-1:0] fd;
    st_valid_i = sv; st_addr_i = sa; st_data_i = sd;
    ld_en_i = le; ld_addr_i = la;
    mem_write_rdy_i = rdy; mem_read_data_i = mrd;
    #1;
    pop     = (q.size() > 0) && rdy;
    rdy_exp = model_ready(rdy);
    hit     = 1'b0;
    fd      = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a[AW-1:3] == la[AW-1:3]) begin
        hit = 1'b1;
        fd  = q[i].d;
        break;
      end
    end
    check("st_ready", st_ready_o, rdy_exp);
    check("mem_write_en", mem_write_en_o, q.size() > 0);
    if (q.size() > 0) begin
      check("mem_addr_store", mem_addr_store_o, q[0].a);
      check("mem_write_data", mem_write_data_o, q[0].d);
    end
    check("mem_read_en", mem_read_en_o, le && !hit);
    if (le && !hit) check("mem_addr_load", mem_addr_load_o, la);
    check("count", count_o, q.size());
    check("count_le_depth", count_o <= DEPTH, 1'b1);
    check("empty", empty_o, q.size() == 0);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (sv && rdy_exp) q.push_back('{sa, sd});
    if (le) begin
      last_d = hit ? fd : mrd;
      last_f = hit;
    end
    check("ld_valid", ld_valid_o, le);
    check("ld_data", ld_data_o, last_d);
    check("ld_fwd", ld_fwd_o, last_f);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 1'b0, '0, rdy, '0);
  endtask

  initial begin
    logic [DW-1:0] exp_d [4];
    int            pushes;
    int            cyc;
    logic          rdy, sv, le;
    logic [AW-1:0] sa, la;

    reset = 1'b0;
    st_valid_i = 0; st_addr_i = '0; st_data_i = '0;
    ld_en_i = 0; ld_addr_i = '0; mem_write_rdy_i = 0; mem_read_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty_o, 1'b1);
    check("rst_st_ready", st_ready_o, 1'b1);
    check("rst_ld_valid", ld_valid_o, 1'b0);
    check("rst_ld_fwd", ld_fwd_o, 1'b0);
    check("rst_ld_data", ld_data_o, '0);
    check("rst_wr_en", mem_write_en_o, 1'b0);
    reset = 1'b1;

    // Reset mid-traffic with three entries buffered.
    step(1, 64'h100, 64'h1, 0, '0, 0, '0);
    step(1, 64'h108, 64'h2, 1, 64'h100, 0, '0);
    step(1, 64'h110, 64'h3, 0, '0, 0, '0);
    check("pre_rst_count", count_o, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_empty", empty_o, 1'b1);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_wr_en", mem_write_en_o, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    last_d = '0;
    last_f = 1'b0;

    // Fill with memory stalled, then drain in order.
    step(1, 64'h10, 64'hA, 0, '0, 0, '0);
    step(1, 64'h18, 64'hB, 0, '0, 0, '0);
    step(1, 64'h20, 64'hC, 0, '0, 0, '0);
    step(1, 64'h28, 64'hD, 0, '0, 0, '0);
    check("full_count", count_o, 4);
    check("full_not_ready", st_ready_o, 1'b0);
    exp_d = '{64'hA, 64'hB, 64'hC, 64'hD};
    for (int k = 0; k < 4; k++) begin
      check("drain_order", mem_write_data_o, exp_d[k]);
      idle(1'b1);
    end
    check("drain_empty", empty_o, 1'b1);

    // Forwarding picks the youngest match; low address bits ignored.
    step(1, 64'h40, 64'h1111, 0, '0, 0, '0);
    step(1, 64'h40, 64'h2222, 0, '0, 0, '0);
    step(0, '0, '0, 1, 64'h44, 0, 64'hFFFF);
    check("fwd_data", ld_data_o, 64'h2222);
    check("fwd_flag", ld_fwd_o, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Miss returns memory data.
    step(0, '0, '0, 1, 64'h80, 0, 64'hDEAD);
    check("miss_data", ld_data_o, 64'hDEAD);
    check("miss_fwd", ld_fwd_o, 1'b0);

    // Store and load to the same address in one cycle: load misses.
    step(1, 64'h60, 64'h5, 1, 64'h60, 0, 64'hBEEF);
    check("samecyc_data", ld_data_o, 64'hBEEF);
    check("samecyc_fwd", ld_fwd_o, 1'b0);
    // Load of the head while it pops still forwards.
    step(0, '0, '0, 1, 64'h60, 1, 64'hBEEF);
    check("headpop_data", ld_data_o, 64'h5);
    check("headpop_fwd", ld_fwd_o, 1'b1);
    check("headpop_empty", empty_o, 1'b1);

    // Wrap: 3*DEPTH pushes with rdy toggling every cycle, random loads.
    pushes = 0;
    cyc = 0;
    while (pushes < 3 * DEPTH && cyc < 200) begin
      rdy = cyc[0];
      sv  = model_ready(rdy);
      sa  = (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
      le  = 1'($urandom_range(0, 1));
      la  = (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
      step(sv, sa, {$urandom, $urandom}, le, la, rdy, {$urandom, $urandom});
      if (sv) pushes++;
      cyc++;
    end
    check("wrap_pushes", pushes, 3 * DEPTH);

    // Random traffic with random memory readiness.
    for (int n = 0; n < 300; n++) begin
      rdy = 1'($urandom_range(0, 1));
      sv  = model_ready(rdy) && ($urandom_range(0, 3) != 0);
      sa  = (64'($urandom_range(0, 5)) << 3) | 64'($urandom_range(0, 7));
      le  = 1'($urandom_range(0, 1));
      la  = (64'($urandom_range(0, 5)) << 3) | 64'($urandom_range(0, 7));
      step(sv, sa, {$urandom, $urandom}, le, la, rdy, {$urandom, $urandom});
    end
    for (int n = 0; n < DEPTH + 1; n++) idle(1'b1);
    check("final_empty", empty_o, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
